alu_writeback: RTL and testbench
================================

// Module: alu_writeback
// PURPOSE
//  Result-writeback stage directly downstream of the combinational ALU. It captures alu_out (2N wide),
//  opcode and destination register over a valid/ready handshake, then writes the result into the
//  N-bit register file and updates the status flags.
//  Narrow results take one RF write. Multiply results (2N bits) take two: lo to dest, hi to dest+1.
// PARAMETERS
//  N          8  datapath/register width; ALU result is 2N bits
//  AW         3  register-file address width (2**AW registers)
// PORTS
//  clk        in   1     single clock, rising edge
//  reset_n    in   1     asynchronous, active-low reset
//  in_valid   in   1     ALU result valid this cycle
//  in_ready   out  1     stage can accept; transfer when in_valid && in_ready
//  in_op      in   4     opcode that produced in_result (ALU encoding)
//  in_result  in   2N    ALU output
//  in_dest    in   AW    destination register
//  rf_we      out  1     register-file write enable (one-cycle pulse per write)
//  rf_waddr   out  AW    register-file write address
//  rf_wdata   out  N     register-file write data
//  flag_zero  out  1     last committed result was zero
//  flag_carry out  1     carry/borrow of last committed add/sub
//  busy       out  1     transaction in flight (state != IDLE)
// BEHAVIOUR
//  Reset (async assert, sync deassert by system): state=IDLE; rf_we=0, rf_waddr=0, rf_wdata=0,
//   flag_zero=0, flag_carry=0, busy=0, in_ready=1. Reset mid-transaction drops it; no partial write follows.
//  Opcodes: 0001 add, 0010 and, 0011 sub, 0100 or, 0101 xor, 0110 min, 0111 jump, 1000 mult, 1001 div,
//   others treated as add. mult is wide; 0111 jump is no-write; all others are narrow.
//  FSM: IDLE, WR_LO, WR_HI. All outputs are registered.
//   IDLE  --accept, narrow/wide--> WR_LO;  IDLE --accept jump--> IDLE (consumed, no write, flags hold)
//   WR_LO: rf_we=1, waddr=dest_q, wdata=result_q[N-1:0]; wide -> WR_HI; narrow -> IDLE or WR_LO on new accept
//   WR_HI: rf_we=1, waddr=dest_q+1 (mod 2**AW, so 2**AW-1 wraps to 0), wdata=result_q[2N-1:N];
//          -> IDLE, or WR_LO on new accept
//  Latency: accept at edge k gives the lo write visible in cycle k+1. The wide hi write is in cycle k+2.
//  in_ready = (state==IDLE) || (state==WR_LO && !wide_q) || (state==WR_HI); it is combinational from state only.
//   This gives back-to-back throughput of 1 narrow op/cycle with no bubble. in_ready is never a function of in_valid.
//  in_valid without in_ready: inputs are held by upstream and not sampled. No-write ops still need in_ready.
//  Flags update in the cycle of the final write of a transaction (the lo write for narrow ops, hi for wide):
//   flag_zero = (narrow: result_q[N-1:0]==0; wide: result_q==0)
//   flag_carry = result_q[N] for add/sub (incl. default-as-add), 0 for every other write op
//  Division by zero is not detected here; the write proceeds with whatever the ALU produced.
// STRUCTURE
//  Shared package alu_pkg: opcode localparams (OP_ADD..OP_DIV, OP_JMP), wb_state_e enum {IDLE,WR_LO,WR_HI},
//   and the function is_wide(op).
//  Optional sub-module alu_flag_gen: combinational zero/carry from result, op and wide.
//   The FSM and registers stay in alu_writeback.
// TESTING (N=8, AW=3)
//  add 0x0105 dest 3 -> cyc+1: rf_we=1, waddr=3, wdata=0x05; flag_carry=1, flag_zero=0; in_ready stays 1
//  mult 0x1234 dest 7 -> cyc+1: we@7=0x34, in_ready=0; cyc+2: we@0=0x12 (wrap); flag_zero=0, flag_carry=0
//  sub 0x0100 dest 2 -> we@2=0x00, flag_zero=1, flag_carry=1; then jump 0111 -> rf_we=0, flags unchanged
//  3 back-to-back narrow ops (xor dest1, or dest2, and dest4) -> rf_we high 3 consecutive cycles, in order, no stall
//  mult accepted, reset_n low during WR_LO -> rf_we=0 immediately, no hi write after release, in_ready=1
//  in_valid held with in_ready=0 during WR_LO of a mult -> held op accepted in WR_HI cycle, its write follows next cycle

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode encodings, writeback FSM states and opcode class helpers
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_OR   = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_MIN  = 4'b0110;
  localparam logic [3:0] OP_JMP  = 4'b0111;
  localparam logic [3:0] OP_MULT = 4'b1000;
  localparam logic [3:0] OP_DIV  = 4'b1001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_LO = 2'd1,
    WR_HI = 2'd2
  } wb_state_e;

  function automatic logic is_wide(input logic [3:0] op);
    return op == OP_MULT;
  endfunction

  // Unlisted encodings fall back to add, so they carry like add/sub.
  function automatic logic is_addsub(input logic [3:0] op);
    case (op)
      OP_AND, OP_OR, OP_XOR, OP_MIN, OP_JMP, OP_MULT, OP_DIV: return 1'b0;
      default:                                               return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/alu_flag_gen.sv
// rtl/alu_flag_gen.sv - combinational zero/carry flags for a committed ALU result
import alu_pkg::*;

module alu_flag_gen #(
  parameter int N = 8
) (
  input  logic [2*N-1:0] result,
  input  logic [3:0]     op,
  input  logic           wide,
  output logic           zero,
  output logic           carry
);

  assign zero  = wide ? (result == '0) : (result[N-1:0] == '0);
  assign carry = is_addsub(op) ? result[N] : 1'b0;

endmodule

// File: rtl/alu_writeback.sv
// rtl/alu_writeback.sv - ALU result writeback into the register file with status flag update
import alu_pkg::*;

module alu_writeback #(
  parameter int N  = 8,
  parameter int AW = 3
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [3:0]     in_op,
  input  logic [2*N-1:0] in_result,
  input  logic [AW-1:0]  in_dest,
  output logic           rf_we,
  output logic [AW-1:0]  rf_waddr,
  output logic [N-1:0]   rf_wdata,
  output logic           flag_zero,
  output logic           flag_carry,
  output logic           busy
);

  wb_state_e       state;
  logic [2*N-1:0]  result_q;
  logic [3:0]      op_q;
  logic [AW-1:0]   dest_q;
  logic            wide_q;

  logic            accept;
  logic            hi_step;
  logic [2*N-1:0]  fg_result;
  logic [3:0]      fg_op;
  logic            fg_wide;
  logic            fg_zero;
  logic            fg_carry;

  assign in_ready = (state == IDLE) || (state == WR_LO && !wide_q) || (state == WR_HI);
  assign busy     = (state != IDLE);
  assign accept   = in_valid && in_ready;
  assign hi_step  = (state == WR_LO) && wide_q;

  // One flag generator serves both the narrow write at accept time and the hi write of a mult.
  assign fg_result = hi_step ? result_q : in_result;
  assign fg_op     = hi_step ? op_q : in_op;
  assign fg_wide   = hi_step;

  alu_flag_gen #(.N(N)) u_flag_gen (
    .result (fg_result),
    .op     (fg_op),
    .wide   (fg_wide),
    .zero   (fg_zero),
    .carry  (fg_carry)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      result_q   <= '0;
      op_q       <= '0;
      dest_q     <= '0;
      wide_q     <= 1'b0;
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      flag_zero  <= 1'b0;
      flag_carry <= 1'b0;
    end else if (hi_step) begin
      state      <= WR_HI;
      rf_we      <= 1'b1;
      rf_waddr   <= dest_q + AW'(1);
      rf_wdata   <= result_q[2*N-1:N];
      flag_zero  <= fg_zero;
      flag_carry <= fg_carry;
    end else if (accept && in_op != OP_JMP) begin
      state    <= WR_LO;
      result_q <= in_result;
      op_q     <= in_op;
      dest_q   <= in_dest;
      wide_q   <= is_wide(in_op);
      rf_we    <= 1'b1;
      rf_waddr <= in_dest;
      rf_wdata <= in_result[N-1:0];
      if (!is_wide(in_op)) begin
        flag_zero  <= fg_zero;
        flag_carry <= fg_carry;
      end
    end else begin
      // Idle cycle or an accepted jump: no write, flags hold.
      state <= IDLE;
      rf_we <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_writeback.sv
// tb/tb_alu_writeback.sv - scoreboard testbench for alu_writeback
module tb_alu_writeback;

  typedef struct {
    logic [2:0] addr;
    logic [7:0] data;
    int         cyc;
    logic       final_wr;
    logic       zero;
    logic       carry;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_op = 4'd0;
  logic [15:0] in_result = 16'd0;
  logic [2:0]  in_dest = 3'd0;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [7:0]  rf_wdata;
  logic        flag_zero;
  logic        flag_carry;
  logic        busy;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  wr_t sb[$];

  alu_writeback #(.N(8), .AW(3)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_result  (in_result),
    .in_dest    (in_dest),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .flag_zero  (flag_zero),
    .flag_carry (flag_carry),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic carries(input logic [3:0] op);
    return !(op inside {4'd2, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9});
  endfunction

  task automatic push_expected(input logic [3:0] op, input logic [15:0] res, input logic [2:0] dest);
    wr_t e;
    if (op == 4'd7) return;
    e.addr = dest;
    e.data = res[7:0];
    e.cyc  = cyc + 1;
    if (op == 4'd8) begin
      e.final_wr = 1'b0;
      e.zero     = 1'b0;
      e.carry    = 1'b0;
      sb.push_back(e);
      e.addr     = dest + 3'd1;
      e.data     = res[15:8];
      e.cyc      = cyc + 2;
      e.final_wr = 1'b1;
      e.zero     = (res == 16'd0);
      e.carry    = 1'b0;
    end else begin
      e.final_wr = 1'b1;
      e.zero     = (res[7:0] == 8'd0);
      e.carry    = carries(op) ? res[8] : 1'b0;
    end
    sb.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge following the transfer edge.
  task automatic send(input logic [3:0] op, input logic [15:0] res, input logic [2:0] dest);
    int guard = 0;
    in_valid  = 1'b1;
    in_op     = op;
    in_result = res;
    in_dest   = dest;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check("ready_timeout", 32'(in_ready), 32'd1);
    else push_expected(op, res, dest);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (reset_n && rf_we) begin
      if (sb.size() == 0) begin
        check("unexpected_write", 32'(rf_waddr), 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("wr_addr", 32'(rf_waddr), 32'(e.addr));
        check("wr_data", 32'(rf_wdata), 32'(e.data));
        check("wr_cycle", 32'(cyc), 32'(e.cyc));
        if (e.final_wr) begin
          check("flag_zero", 32'(flag_zero), 32'(e.zero));
          check("flag_carry", 32'(flag_carry), 32'(e.carry));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_we", 32'(rf_we), 32'd0);
    check("rst_waddr", 32'(rf_waddr), 32'd0);
    check("rst_wdata", 32'(rf_wdata), 32'd0);
    check("rst_zero", 32'(flag_zero), 32'd0);
    check("rst_carry", 32'(flag_carry), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    reset_n = 1'b1;
    @(negedge clk);

    // narrow add with carry out
    send(4'd1, 16'h0105, 3'd3);
    check("add_ready", 32'(in_ready), 32'd1);
    idle(2);

    // wide mult wrapping to register 0
    send(4'd8, 16'h1234, 3'd7);
    check("mult_ready_lo", 32'(in_ready), 32'd0);
    check("mult_busy_lo", 32'(busy), 32'd1);
    idle(1);
    check("mult_hi_addr", 32'(rf_waddr), 32'd0);
    check("mult_ready_hi", 32'(in_ready), 32'd1);
    idle(2);

    // sub giving zero with borrow, then a jump that must leave flags alone
    send(4'd3, 16'h0100, 3'd2);
    idle(1);
    send(4'd7, 16'h00AA, 3'd5);
    check("jmp_we", 32'(rf_we), 32'd0);
    check("jmp_zero", 32'(flag_zero), 32'd1);
    check("jmp_carry", 32'(flag_carry), 32'd1);
    idle(2);

    // back-to-back narrow ops; bit 8 set on the and must not reach carry
    send(4'd5, 16'h00F0, 3'd1);
    send(4'd4, 16'h0003, 3'd2);
    send(4'd2, 16'h0180, 3'd4);
    idle(2);

    // undefined opcode behaves as add
    send(4'hF, 16'h0100, 3'd5);
    idle(2);

    // reset in the middle of a mult drops the hi write
    send(4'd8, 16'hABCD, 3'd6);
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1 check("rst_mid_we", 32'(rf_we), 32'd0);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    idle(4);
    check("rst_mid_ready", 32'(in_ready), 32'd1);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_zero", 32'(flag_zero), 32'd0);

    // op held while a mult is in WR_LO, taken during WR_HI
    send(4'd8, 16'h0200, 3'd1);
    send(4'd1, 16'h01FF, 3'd3);
    idle(3);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
